// File: rtl/multicycle_adder_if.sv
// rtl/multicycle_adder_if.sv - request/result bundle for multicycle_adder; OVF member present only with MULTICYCLE_ADDER_OVF_EN
interface multicycle_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
`ifdef MULTICYCLE_ADDER_OVF_EN
    logic             OVF;

    modport master (
        output start, A, B, Cin,
        input  busy, done, Sum, Cout, OVF
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, Sum, Cout, OVF
    );
`else
    modport master (
        output start, A, B, Cin,
        input  busy, done, Sum, Cout
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, Sum, Cout
    );
`endif
endinterface

// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - slice-serial WIDTH-bit adder, CHUNK bits per cycle; signed overflow flag with MULTICYCLE_ADDER_OVF_EN
module multicycle_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_adder_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    // Latched operands are shifted right each RUN edge, so the slice for
    // index idx always sits in the low CHUNK bits.
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    // Working sum fills from the top: each new slice enters at the MSB end
    // and the earlier ones move down, landing in place after NCHUNK edges.
    logic [WIDTH-1:0] wsum;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] wsum_next;
    logic             last;

`ifdef MULTICYCLE_ADDER_OVF_EN
    logic             ovf_r;
    logic             ovf_next;
`endif

    // One CHUNK-bit slice of the addition plus the merged working sum.
    always_comb begin
        {slice_cout, slice_sum} = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]}
                                + {{CHUNK{1'b0}}, carry};
        wsum_next = (wsum >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
        last      = (idx == IW'(NCHUNK - 1));
    end

`ifdef MULTICYCLE_ADDER_OVF_EN
    // On the final slice the low bits hold the operand MSBs; same-sign
    // operands giving an opposite-sign result is exactly carry-in XOR carry-out of the MSB.
    always_comb begin
        ovf_next = (a_r[CHUNK-1] == b_r[CHUNK-1]) && (slice_sum[CHUNK-1] != a_r[CHUNK-1]);
    end
`endif

    // Control FSM, slice datapath and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            carry  <= 1'b0;
            wsum   <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_r   <= bus.A;
                        b_r   <= bus.B;
                        carry <= bus.Cin;
                        idx   <= '0;
                        wsum  <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_r   <= a_r >> CHUNK;
                    b_r   <= b_r >> CHUNK;
                    carry <= slice_cout;
                    wsum  <= wsum_next;
                    if (last) begin
                        sum_r  <= wsum_next;
                        cout_r <= slice_cout;
`ifdef MULTICYCLE_ADDER_OVF_EN
                        ovf_r  <= ovf_next;
`endif
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
    assign bus.Sum  = sum_r;
    assign bus.Cout = cout_r;
`ifdef MULTICYCLE_ADDER_OVF_EN
    assign bus.OVF  = ovf_r;
`endif

endmodule

// File: tb/tb_multicycle_adder.sv
// tb/tb_multicycle_adder.sv - randomized and directed checks of multicycle_adder (8/2 and 8/8) against an arithmetic model
module tb_multicycle_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic       start8 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] ain    = 8'h00;
    logic [7:0] bin    = 8'h00;
    logic       cinr   = 1'b0;
    bit         cur    = 1'b0;

    multicycle_adder_if #(.WIDTH(8)) bus8 ();
    multicycle_adder_if #(.WIDTH(8)) bus1 ();

    assign bus8.start = start8;
    assign bus8.A     = ain;
    assign bus8.B     = bin;
    assign bus8.Cin   = cinr;
    assign bus1.start = start1;
    assign bus1.A     = ain;
    assign bus1.B     = bin;
    assign bus1.Cin   = cinr;

    multicycle_adder #(.WIDTH(8), .CHUNK(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    wire [7:0] o_sum  = cur ? bus1.Sum  : bus8.Sum;
    wire       o_cout = cur ? bus1.Cout : bus8.Cout;
    wire       o_busy = cur ? bus1.busy : bus8.busy;
    wire       o_done = cur ? bus1.done : bus8.done;
`ifdef MULTICYCLE_ADDER_OVF_EN
    wire       o_ovf  = cur ? bus1.OVF  : bus8.OVF;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int unsigned s;
        s = int'(a) + int'(b) + int'(cin);
        return s[8:0];
    endfunction

    function automatic logic model_ovf(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        return (s > 127) || (s < -128);
    endfunction

    // Present one request to the selected DUT and follow it to completion.
    task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input bit hold);
        logic [8:0] exp;
        logic [7:0] prev;
        int lat, busy_cycles, exp_lat, extra_done;
        exp     = model_sum(a, b, cin);
        exp_lat = sel ? 1 : 4;
        cur     = sel;
        #1;
        prev = o_sum;
        ain  = a;
        bin  = b;
        cinr = cin;
        if (sel) start1 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        check("busy_after_accept", o_busy, 1'b1);
        check("done_after_accept", o_done, 1'b0);
        check("sum_held", o_sum, prev);
        if (hold) begin
            ain  = 8'hFF;
            bin  = 8'hFF;
            cinr = 1'b1;
        end else begin
            start8 = 1'b0;
            start1 = 1'b0;
            ain    = 8'($urandom);
            bin    = 8'($urandom);
            cinr   = 1'($urandom);
        end
        lat = 0;
        busy_cycles = 1;
        while (!o_done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (o_busy) busy_cycles++;
        end
        check("latency", lat, exp_lat);
        check("sum", o_sum, exp[7:0]);
        check("cout", o_cout, exp[8]);
`ifdef MULTICYCLE_ADDER_OVF_EN
        check("ovf", o_ovf, model_ovf(a, b, cin));
`endif
        check("busy_cycles", busy_cycles, exp_lat + 1);
        @(posedge clk); #1;
        check("done_pulse_end", o_done, 1'b0);
        check("busy_end", o_busy, 1'b0);
        start8 = 1'b0;
        start1 = 1'b0;
        if (hold) begin
            extra_done = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (o_done || o_busy) extra_done++;
            end
            check("ignored_start", extra_done, 0);
            check("sum_after_ignore", o_sum, exp[7:0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dones;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy8", bus8.busy, 1'b0);
        check("rst_done8", bus8.done, 1'b0);
        check("rst_sum8", bus8.Sum, 8'h00);
        check("rst_cout8", bus8.Cout, 1'b0);
        check("rst_busy1", bus1.busy, 1'b0);
        check("rst_sum1", bus1.Sum, 8'h00);
`ifdef MULTICYCLE_ADDER_OVF_EN
        check("rst_ovf8", bus8.OVF, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(1'b0, 8'h5A, 8'hA5, 1'b1, 1'b0);
        run_op(1'b0, 8'h10, 8'h20, 1'b0, 1'b1);

        // Reset during the second RUN edge aborts with no done.
        cur    = 1'b0;
        ain    = 8'hF0;
        bin    = 8'h0F;
        cinr   = 1'b0;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus8.busy, 1'b0);
        check("abort_sum", bus8.Sum, 8'h00);
        check("abort_cout", bus8.Cout, 1'b0);
        check("abort_done", bus8.done, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus8.done) dones++;
        end
        check("abort_no_done", dones, 0);
        run_op(1'b0, 8'h03, 8'h04, 1'b0, 1'b0);

        run_op(1'b1, 8'hC8, 8'h64, 1'b0, 1'b0);

        run_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(1'b0, 8'h80, 8'h80, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
